// File: rtl/debug_pkg.sv
// Shared definitions for the debug UART transmitter: FSM encodings,
// frame constants and the byte selector for the 5-byte debug frame.
package debug_pkg;

  // Frame-level sequencer states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  // Byte serializer states
  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

  localparam logic [4:0] HEADER      = 5'b10100;
  localparam int         FRAME_BYTES = 5;

  // Byte idx of the frame: header {HEADER, mode}, then data MSB byte first
  function automatic logic [7:0] frame_byte(input logic [2:0]  m,
                                            input logic [31:0] d,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {HEADER, m};
      3'd1:    b = d[31:24];
      3'd2:    b = d[23:16];
      3'd3:    b = d[15:8];
      default: b = d[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART serializer: start bit, 8 data bits LSB first, stop bit.
// A go seen during the last stop-bit cycle chains the next byte with no gap.
module uart_byte_tx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_go,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_done,
  output logic       o_in_stop
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  ser_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == CNT_MAX);
  assign o_done    = (r_state == SER_STOP) && w_bit_end;
  assign o_in_stop = (r_state == SER_STOP);
  assign o_tx      = r_tx;

  // Bit timing and line drive; tx is registered so the line never glitches
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= SER_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        SER_IDLE: begin
          if (i_go) begin
            r_shift <= i_byte;
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= SER_START;
          end
        end
        SER_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_state <= SER_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SER_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_bit   <= '0;
              r_state <= SER_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[1];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SER_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (i_go) begin
              r_shift <= i_byte;
              r_tx    <= 1'b0;
              r_state <= SER_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= SER_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug UART transmitter: on a send request latches mode/data and sends a
// 5-byte frame (header + 4 payload bytes), then acknowledges with
// doneSending until the request is withdrawn.
module debug_uart_tx
  import debug_pkg::*;
#(
  parameter int freq = 50000000,
  parameter int baud = 115200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tx_flag,
  input  logic [2:0]  mode,
  input  logic [31:0] data_in,
  output logic        tx,
  output logic        doneSending,
  output logic        busy
);

  localparam int CLKS_PER_BIT = freq / baud;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [2:0]  r_mode;
  logic [31:0] r_data;
  logic        r_done;
  logic        r_busy;

  logic        w_chain;
  logic        w_go;
  logic [2:0]  w_sel;
  logic [7:0]  w_byte;
  logic        w_ser_tx;
  logic        w_ser_done;
  logic        w_ser_stop;

  // Handoff to the serializer: first byte from START, later bytes chained
  // in the last stop-bit cycle of the previous byte so there is no gap
  always_comb begin
    w_chain = ((r_state == DATA) || (r_state == STOP)) && w_ser_done &&
              (r_idx != LAST_IDX);
    w_go    = (r_state == START) || w_chain;
    w_sel   = (r_state == START) ? r_idx : (r_idx + 3'd1);
    w_byte  = frame_byte(r_mode, r_data, w_sel);
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .i_go     (w_go),
    .i_byte   (w_byte),
    .o_tx     (w_ser_tx),
    .o_done   (w_ser_done),
    .o_in_stop(w_ser_stop)
  );

  // Payload capture at frame start; later input changes are ignored
  always_ff @(posedge CLK) begin
    if ((r_state == IDLE) && tx_flag) begin
      r_mode <= mode;
      r_data <= data_in;
    end
  end

  // Frame sequencer with registered acknowledge and busy
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_flag) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: r_state <= DATA;
        DATA, STOP: begin
          if (w_ser_done) begin
            if (r_idx != LAST_IDX) begin
              r_idx   <= r_idx + 3'd1;
              r_state <= DATA;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end else if (w_ser_stop) begin
            r_state <= STOP;
          end
        end
        DONE: begin
          if (!tx_flag) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx          = w_ser_tx;
  assign doneSending = r_done;
  assign busy        = r_busy;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx with CLKS_PER_BIT = 16/4 = 4.
module tb_debug_uart_tx;

  logic        CLK = 1'b0;
  logic        RST;
  logic        tx_flag;
  logic [2:0]  mode;
  logic [31:0] data_in;
  logic        tx;
  logic        doneSending;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  debug_uart_tx #(.freq(16), .baud(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .tx_flag    (tx_flag),
    .mode       (mode),
    .data_in    (data_in),
    .tx         (tx),
    .doneSending(doneSending),
    .busy       (busy)
  );

  // Decode nbytes UART bytes (4 clocks per bit), sampling mid-bit on negedges.
  // When byte chg_idx starts, the payload inputs are overwritten.
  task automatic rx_frame(input int nbytes, input int chg_idx,
                          output logic [39:0] f, output int t0);
    logic [7:0] b;
    int wait_n;
    f  = '0;
    t0 = 0;
    b  = '0;
    for (int i = 0; i < nbytes; i++) begin
      wait_n = 0;
      while (tx !== 1'b0 && wait_n < 100) begin
        @(negedge CLK);
        wait_n++;
      end
      if (tx !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL start_bit byte %0d: tx=%b required 0", i, tx);
        return;
      end
      if (i == 0) t0 = cyc;
      if (i == chg_idx) begin
        data_in = 32'h12345678;
        mode    = 3'b111;
      end
      repeat (6) @(negedge CLK);
      for (int k = 0; k < 8; k++) begin
        b[k] = tx;
        if (k < 7) repeat (4) @(negedge CLK);
      end
      repeat (4) @(negedge CLK);
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL stop_bit byte %0d: tx=%b required 1", i, tx);
      end
      f = {f[31:0], b};
    end
  endtask

  task automatic wait_done(output int td);
    int n;
    n = 0;
    while (doneSending !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    td = cyc;
    checks++;
    if (doneSending !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: doneSending=%b required 1", doneSending);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tx_flag = 1'b0;
    mode = 3'b000;
    data_in = 32'h0;
    repeat (2) @(negedge CLK);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: tx=%b required 1", tx); end
    checks++;
    if (doneSending !== 1'b0) begin errors++; $display("FAIL reset_done: doneSending=%b required 0", doneSending); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b required 0", busy); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_frame();
    logic [39:0] f;
    int t0, td;
    bit bad;
    mode = 3'b001;
    data_in = 32'hDEADBEEF;
    tx_flag = 1'b1;
    @(negedge CLK);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL latency_tx_high: tx=%b required 1", tx); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy: busy=%b required 1", busy); end
    @(negedge CLK);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL latency_tx_low: tx=%b required 0", tx); end
    rx_frame(5, -1, f, t0);
    checks++;
    if (f !== 40'hA1DEADBEEF) begin errors++; $display("FAIL frame_bytes: got %h required a1deadbeef", f); end
    wait_done(td);
    checks++;
    if (td - t0 != 200) begin errors++; $display("FAIL frame_time: got %0d cycles required 200", td - t0); end
    // Request held: acknowledge stays up, no retrigger
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (tx !== 1'b1 || doneSending !== 1'b1 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL hold_no_retrigger: tx=%b done=%b busy=%b required 1 1 1", tx, doneSending, busy); end
    tx_flag = 1'b0;
    @(negedge CLK);
    checks++;
    if (doneSending !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: done=%b busy=%b required 0 0", doneSending, busy);
    end
  endtask

  task automatic test_pulse();
    logic [39:0] f;
    int t0, td, n;
    mode = 3'b110;
    data_in = 32'h0;
    tx_flag = 1'b1;
    @(negedge CLK);
    tx_flag = 1'b0;
    rx_frame(5, -1, f, t0);
    checks++;
    // header is {10100, 110} = 8'hA6
    if (f !== 40'hA600000000) begin errors++; $display("FAIL pulse_bytes: got %h required a600000000", f); end
    wait_done(td);
    checks++;
    if (td - t0 != 200) begin errors++; $display("FAIL pulse_time: got %0d cycles required 200", td - t0); end
    n = 0;
    while (doneSending === 1'b1 && n < 10) begin
      n++;
      @(negedge CLK);
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL pulse_done_width: got %0d cycles required 1", n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL pulse_busy: busy=%b required 0", busy); end
  endtask

  task automatic test_midframe_change();
    logic [39:0] f;
    int t0, td;
    mode = 3'b010;
    data_in = 32'hCAFEF00D;
    tx_flag = 1'b1;
    @(negedge CLK);
    tx_flag = 1'b0;
    rx_frame(5, 2, f, t0);
    checks++;
    if (f !== 40'hA2CAFEF00D) begin errors++; $display("FAIL latched_payload: got %h required a2cafef00d", f); end
    wait_done(td);
    @(negedge CLK);
  endtask

  task automatic test_reset_midframe();
    logic [39:0] f;
    int t0, td, n;
    bit bad;
    mode = 3'b101;
    data_in = 32'h11223344;
    tx_flag = 1'b1;
    @(negedge CLK);
    tx_flag = 1'b0;
    rx_frame(3, -1, f, t0);
    checks++;
    if (f[23:0] !== 24'hA51122) begin errors++; $display("FAIL partial_bytes: got %h required a51122", f[23:0]); end
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (tx !== 1'b1 || doneSending !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: tx=%b done=%b busy=%b required 1 0 0", tx, doneSending, busy);
    end
    RST = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge CLK);
      if (tx !== 1'b1 || doneSending !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL post_reset_quiet: tx=%b done=%b busy=%b required 1 0 0", tx, doneSending, busy); end
    mode = 3'b100;
    data_in = 32'h0F1E2D3C;
    tx_flag = 1'b1;
    @(negedge CLK);
    tx_flag = 1'b0;
    rx_frame(5, -1, f, t0);
    checks++;
    if (f !== 40'hA40F1E2D3C) begin errors++; $display("FAIL after_reset_bytes: got %h required a40f1e2d3c", f); end
    wait_done(td);
    checks++;
    if (td - t0 != 200) begin errors++; $display("FAIL after_reset_time: got %0d cycles required 200", td - t0); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_pulse();
    test_midframe_change();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
